// File: rtl/xgmii_tx_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_tx_mon_if
// Brief    : 64-bit XGMII TX bus (txd/txc) as observed by the TX monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface xgmii_tx_mon_if;
    logic [63:0] txd;
    logic [7:0]  txc;

    modport master (output txd, output txc);
    modport slave  (input  txd, input  txc);
endinterface
`default_nettype wire

// File: rtl/xgmii_tx_mon.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_tx_mon
// Brief    : Passive XGMII TX frame monitor: length, framing checks, counters.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_tx_mon #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  wire logic           clk156,
    input  wire logic           rst,
    xgmii_tx_mon_if.slave       xgmii,
    input  wire logic           clr_cnt,
    output logic                frame_done,
    output logic [15:0]         frame_len,
    output logic [4:0]          frame_err,
    output logic                stray_err,
    output logic [31:0]         frame_cnt,
    output logic [31:0]         byte_cnt,
    output logic [15:0]         err_cnt
);

    localparam logic [7:0]  c_idle     = 8'h07;
    localparam logic [7:0]  c_start    = 8'hFB;
    localparam logic [7:0]  c_term     = 8'hFD;
    localparam logic [63:0] c_preamble = 64'hD5555555555555FB;
    localparam logic [15:0] c_min      = 16'(MIN_LEN);
    localparam logic [15:0] c_max      = 16'(MAX_LEN);

    typedef enum logic {IDLE, DATA} state_t;

    state_t      r_state;
    logic [15:0] r_len;
    logic [4:0]  r_err;

    logic [3:0]  w_first;
    logic [7:0]  w_first_char;
    logic        w_upper_idle;
    logic        w_all_idle;
    logic        w_start;
    logic        w_pre_bad;
    logic        w_term_ok;
    logic [16:0] w_sum;
    logic        w_end;
    logic        w_open;
    logic        w_stray;
    logic [15:0] w_acc_len;
    logic [4:0]  w_acc_err;
    logic [4:0]  w_end_err;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    // Word decode: w_first is the lowest control lane (8 when the word is all data).
    always_comb begin
        w_first      = 4'd8;
        w_first_char = 8'h00;
        w_upper_idle = 1'b1;
        w_all_idle   = (xgmii.txc == 8'hFF);
        for (int i = 7; i >= 0; i--) begin
            if (xgmii.txc[i]) begin
                w_first = 4'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (xgmii.txd[8*i +: 8] != c_idle) begin
                w_all_idle = 1'b0;
            end
            if (4'(i) == w_first) begin
                w_first_char = xgmii.txd[8*i +: 8];
            end
            if ((4'(i) > w_first) && (xgmii.txd[8*i +: 8] != c_idle)) begin
                w_upper_idle = 1'b0;
            end
        end
        w_start   = (xgmii.txc == 8'h01) && (xgmii.txd[7:0] == c_start);
        w_pre_bad = (xgmii.txd != c_preamble);
        w_term_ok = (xgmii.txc == 8'(8'hFF << w_first)) && w_upper_idle;
        w_sum     = {1'b0, r_len} + {13'd0, w_first};
    end

    // Frame tracking; w_acc_* is the frame state after this word is absorbed.
    always_comb begin
        w_end     = 1'b0;
        w_open    = 1'b0;
        w_stray   = 1'b0;
        w_acc_len = r_len;
        w_acc_err = r_err;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_open = 1'b1;
                end else if (!w_all_idle) begin
                    w_stray = 1'b1;
                end
            end
            DATA: begin
                if (w_start) begin
                    w_end        = 1'b1;
                    w_open       = 1'b1;
                    w_acc_err[4] = 1'b1;
                end else begin
                    if (w_sum[16]) begin
                        w_acc_len    = 16'hFFFF;
                        w_acc_err[1] = 1'b1;
                    end else begin
                        w_acc_len = w_sum[15:0];
                    end
                    if (xgmii.txc != 8'h00) begin
                        if (w_first_char == c_term) begin
                            w_end = 1'b1;
                            if (!w_term_ok) begin
                                w_acc_err[2] = 1'b1;
                            end
                        end else begin
                            w_acc_err[2] = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        w_end_err = w_acc_err;
        if (w_acc_len < c_min) begin
            w_end_err[0] = 1'b1;
        end
        if (w_acc_len > c_max) begin
            w_end_err[1] = 1'b1;
        end
        w_err_inc = {1'b0, (w_end && (w_end_err != 5'd0))} + {1'b0, w_stray};
        w_err_sum = {1'b0, err_cnt} + {15'd0, w_err_inc};
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= 16'd0;
            r_err      <= 5'd0;
            frame_done <= 1'b0;
            frame_len  <= 16'd0;
            frame_err  <= 5'd0;
            stray_err  <= 1'b0;
            frame_cnt  <= 32'd0;
            byte_cnt   <= 32'd0;
            err_cnt    <= 16'd0;
        end else begin
            if (w_open) begin
                r_state <= DATA;
                r_len   <= 16'd0;
                r_err   <= w_pre_bad ? 5'b01000 : 5'b00000;
            end else if (w_end) begin
                r_state <= IDLE;
            end else if (r_state == DATA) begin
                r_len <= w_acc_len;
                r_err <= w_acc_err;
            end

            frame_done <= w_end;
            stray_err  <= w_stray;
            if (w_end) begin
                frame_len <= w_acc_len;
                frame_err <= w_end_err;
            end

            if (clr_cnt) begin
                frame_cnt <= 32'd0;
                byte_cnt  <= 32'd0;
                err_cnt   <= 16'd0;
            end else begin
                if (w_end && (w_end_err == 5'd0)) begin
                    frame_cnt <= frame_cnt + 32'd1;
                    byte_cnt  <= byte_cnt + {16'd0, w_acc_len};
                end
                err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_tx_mon
// Brief    : Scoreboard bench for xgmii_tx_mon with directed frame vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_tx_mon;

    typedef struct {
        logic [15:0] len;
        logic [4:0]  err;
        logic [31:0] fc;
        logic [31:0] bc;
        logic [15:0] ec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [4:0]  frame_err;
    logic        stray_err;
    logic [31:0] frame_cnt;
    logic [31:0] byte_cnt;
    logic [15:0] err_cnt;

    exp_t        exp_q[$];
    logic [15:0] stray_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_fc = 0;
    logic [31:0] m_bc = 0;
    logic [15:0] m_ec = 0;

    xgmii_tx_mon_if bus();

    xgmii_tx_mon #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk156    (clk),
        .rst       (rst),
        .xgmii     (bus),
        .clr_cnt   (clr_cnt),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .frame_err (frame_err),
        .stray_err (stray_err),
        .frame_cnt (frame_cnt),
        .byte_cnt  (byte_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c, input logic clr);
        @(posedge clk);
        #1;
        bus.txd = d;
        bus.txc = c;
        clr_cnt = clr;
    endtask

    task automatic idle_word();
        send({8{8'h07}}, 8'hFF, 1'b0);
    endtask

    task automatic start_word(input logic [63:0] pre);
        send(pre, 8'h01, 1'b0);
    endtask

    task automatic data_words(input int n);
        for (int i = 0; i < n; i++) send({$urandom, $urandom}, 8'h00, 1'b0);
    endtask

    function automatic logic [63:0] term_word(input int k);
        logic [63:0] w;
        w = 64'h1122334455667788;
        for (int i = 0; i < 8; i++) begin
            if (i == k) w[8*i +: 8] = 8'hFD;
            else if (i > k) w[8*i +: 8] = 8'h07;
        end
        return w;
    endfunction

    // Model of the stats counters; each expected frame carries post-update counts.
    task automatic expect_frame(input logic [15:0] len, input logic [4:0] err, input logic clr);
        exp_t e;
        if (clr) begin
            m_fc = 0; m_bc = 0; m_ec = 0;
        end else if (err == 5'd0) begin
            m_fc = m_fc + 1;
            m_bc = m_bc + {16'd0, len};
        end else if (m_ec != 16'hFFFF) begin
            m_ec = m_ec + 1;
        end
        e.len = len; e.err = err; e.fc = m_fc; e.bc = m_bc; e.ec = m_ec;
        exp_q.push_back(e);
    endtask

    task automatic good_frame64();
        start_word(64'hD5555555555555FB);
        data_words(8);
        expect_frame(16'd64, 5'd0, 1'b0);
        send(term_word(0), 8'hFF, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_len", {16'd0, frame_len}, {16'd0, e.len});
                    chk("frame_err", {27'd0, frame_err}, {27'd0, e.err});
                    chk("frame_cnt", frame_cnt, e.fc);
                    chk("byte_cnt", byte_cnt, e.bc);
                    chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.ec});
                end
            end
            if (stray_err) begin
                if (stray_q.size() == 0) begin
                    chk("unexpected_stray_err", 32'd1, 32'd0);
                end else begin
                    logic [15:0] se;
                    se = stray_q.pop_front();
                    chk("stray_err_cnt", {16'd0, err_cnt}, {16'd0, se});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        rst     = 1'b1;
        clr_cnt = 1'b0;
        bus.txd = 64'hD5555555555555FB;
        bus.txc = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
            chk("rst_outputs", {frame_len, 11'd0, frame_err},  32'd0);
            chk("rst_stray", {31'd0, stray_err}, 32'd0);
            chk("rst_counters", frame_cnt | byte_cnt | {16'd0, err_cnt}, 32'd0);
        end
        bus.txd = {8{8'h07}};
        bus.txc = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_word();

        // 64-byte good frame
        good_frame64();
        idle_word();

        // 60-byte runt ending in lane 4
        start_word(64'hD5555555555555FB);
        data_words(7);
        expect_frame(16'd60, 5'b00001, 1'b0);
        send(term_word(4), 8'hF0, 1'b0);
        idle_word();

        // bad preamble
        start_word(64'hD5555555555554FB);
        data_words(8);
        expect_frame(16'd64, 5'b01000, 1'b0);
        send(term_word(0), 8'hFF, 1'b0);
        idle_word();

        // terminate with a non-idle control char above FD
        start_word(64'hD5555555555555FB);
        data_words(8);
        w = term_word(0);
        w[15:8] = 8'h55;
        expect_frame(16'd64, 5'b00100, 1'b0);
        send(w, 8'hFF, 1'b0);

        // two starts without terminate
        start_word(64'hD5555555555555FB);
        data_words(8);
        expect_frame(16'd64, 5'b10000, 1'b0);
        start_word(64'hD5555555555555FB);
        data_words(8);
        expect_frame(16'd64, 5'd0, 1'b0);
        send(term_word(0), 8'hFF, 1'b0);
        idle_word();

        // data word while idle
        m_ec = m_ec + 1;
        stray_q.push_back(m_ec);
        send(64'h0123456789ABCDEF, 8'h00, 1'b0);
        idle_word();

        // clear coincident with a good frame end
        start_word(64'hD5555555555555FB);
        data_words(8);
        expect_frame(16'd64, 5'd0, 1'b1);
        send(term_word(0), 8'hFF, 1'b1);
        idle_word();

        // 1600-byte giant
        start_word(64'hD5555555555555FB);
        data_words(200);
        expect_frame(16'd1600, 5'b00010, 1'b0);
        send(term_word(0), 8'hFF, 1'b0);

        // 200 back-to-back good frames
        for (int f = 0; f < 200; f++) good_frame64();
        idle_word();
        repeat (4) idle_word();

        chk("final_frame_cnt", frame_cnt, 32'd200);
        chk("final_byte_cnt", byte_cnt, 32'd12800);
        chk("final_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("frames_pending", exp_q.size(), 32'd0);
        chk("strays_pending", stray_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
